// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment display driver
package seg_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seg4_display_hex_to_sseg.sv
// hex_to_sseg: combinational hex nibble to active-low {g..a} segment decoder
module hex_to_sseg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/seg4_display.sv
// seg4_display: time-multiplexed 4-digit common-anode 7-segment driver
module seg4_display
  import seg_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg
);
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0] sel;
  logic [3:0] hex_sel, an_q, an_d;
  logic [6:0] seg;
  logic [7:0] sseg_q, sseg_d;
  assign cnt_d = cnt_q + REFRESH_BITS'(1);
  assign sel = cnt_q[REFRESH_BITS-1 -: 2];
  assign hex_sel = sel == 2'd0 ? hex0 : sel == 2'd1 ? hex1 : sel == 2'd2 ? hex2 : hex3;
  assign an_d = ~(4'b0001 << sel);
  assign sseg_d = {~dp_in[sel], seg};
  hex_to_sseg u_dec (.hex_i(hex_sel), .seg_o(seg));
  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
      an_q <= AN_OFF;
      sseg_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      an_q <= an_d;
      sseg_q <= sseg_d;
    end
  end
  assign an = an_q;
  assign sseg = sseg_q;
endmodule

// File: tb/tb_seg4_display.sv
// tb_seg4_display: scoreboard bench for seg4_display with REFRESH_BITS=4
module tb_seg4_display;
  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    string nm;
  } exp_t;
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 0, rst_n = 1;
  logic [3:0] hex0 = 0, hex1 = 0, hex2 = 0, hex3 = 0, dp_in = 0;
  logic [3:0] an;
  logic [7:0] sseg;
  exp_t q[$];
  int checks = 0, fails = 0;
  seg4_display #(.REFRESH_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp_in(dp_in), .an(an), .sseg(sseg)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (an !== e.an || sseg !== e.sseg) begin
        fails++;
        $display("FAIL %s: got an=%b sseg=%h, expected an=%b sseg=%h", e.nm, an, sseg, e.an, e.sseg);
      end
    end
  end
  task automatic tick(input logic [3:0] ea, input logic [7:0] es, input string nm);
    exp_t e;
    @(posedge clk);
    e.an = ea;
    e.sseg = es;
    e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic dwell(input logic [3:0] ea, input logic [7:0] es, input string nm);
    for (int i = 0; i < 4; i++) tick(ea, es, nm);
  endtask
  initial begin
    for (int i = 0; i < 20; i++) tick(4'hF, 8'hFF, "reset_hold");
    {hex3, hex2, hex1, hex0} = 16'h2202;
    dp_in = 4'b1000;
    rst_n = 0;
    dwell(4'b1110, 8'hA4, "p1_d0");
    dwell(4'b1101, 8'hC0, "p1_d1");
    dwell(4'b1011, 8'hA4, "p1_d2");
    dwell(4'b0111, 8'h24, "p1_d3");
    {hex3, hex2, hex1, hex0} = 16'h8110;
    dp_in = 4'b0000;
    dwell(4'b1110, 8'hC0, "p2_d0");
    dwell(4'b1101, 8'hF9, "p2_d1");
    dwell(4'b1011, 8'hF9, "p2_d2");
    dwell(4'b0111, 8'h80, "p2_d3");
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      hex0 = vv;
      dp_in = {3'b000, vv[0]};
      tick(4'b1110, {~vv[0], TBL[v]}, $sformatf("decode_%h", vv));
      if (v % 4 == 3) begin
        dp_in = 4'b0000;
        dwell(4'b1101, 8'hF9, "sweep_d1");
        dwell(4'b1011, 8'hF9, "sweep_d2");
        dwell(4'b0111, 8'h80, "sweep_d3");
      end
    end
    hex0 = 0;
    hex1 = 1;
    dp_in = 0;
    dwell(4'b1110, 8'hC0, "lat_d0");
    tick(4'b1101, 8'hF9, "lat_before");
    tick(4'b1101, 8'hF9, "lat_before");
    hex1 = 7;
    tick(4'b1101, 8'hF8, "lat_after");
    tick(4'b1101, 8'hF8, "lat_after");
    tick(4'b1011, 8'hF9, "mid_d2");
    tick(4'b1011, 8'hF9, "mid_d2");
    rst_n = 1;
    tick(4'hF, 8'hFF, "mid_reset");
    tick(4'hF, 8'hFF, "mid_reset");
    rst_n = 0;
    dwell(4'b1110, 8'hC0, "restart_d0");
    tick(4'b1101, 8'hF8, "restart_d1");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
